// File: rtl/multicycle_main_controller_pkg.sv
// multicycle_main_controller_pkg: state encodings, opcodes, datapath select codes and the control word
package multicycle_main_controller_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, TRAP
  } state_t;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_DATA = 2'b01, RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_FUNCT = 2'b10;
  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10, IMM_J = 2'b11;
  typedef struct packed {
    logic       mem_req;
    logic       mem_wait;
    logic       pc_update;
    logic       branch;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       illegal;
    logic       done;
  } ctrl_t;
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    return op == OP_SW ? IMM_S : op == OP_BEQ ? IMM_B : op == OP_JAL ? IMM_J : IMM_I;
  endfunction
  function automatic logic known_op(input logic [6:0] op);
    return op == OP_LW || op == OP_SW || op == OP_R || op == OP_I || op == OP_BEQ || op == OP_JAL;
  endfunction
endpackage

// File: rtl/multicycle_main_controller_state_out_decode.sv
// multicycle_main_controller_state_out_decode: combinational state to control-word table
module multicycle_main_controller_state_out_decode
  import multicycle_main_controller_pkg::*;
(
  input  state_t s,
  output ctrl_t  cw
);
  always_comb begin
    cw = '0;
    case (s)
      FETCH: begin
        cw.mem_req    = 1'b1;
        cw.mem_wait   = 1'b1;
        cw.ir_write   = 1'b1;
        cw.pc_update  = 1'b1;
        cw.alu_src_a  = SRCA_PC;
        cw.alu_src_b  = SRCB_FOUR;
        cw.alu_op     = ALU_ADD;
        cw.result_src = RES_ALURESULT;
      end
      DECODE: begin
        cw.alu_src_a = SRCA_OLDPC;
        cw.alu_src_b = SRCB_IMM;
      end
      MEMADR: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_IMM;
      end
      MEMREAD: begin
        cw.mem_req  = 1'b1;
        cw.mem_wait = 1'b1;
        cw.adr_src  = 1'b1;
      end
      MEMWB: begin
        cw.result_src = RES_DATA;
        cw.reg_write  = 1'b1;
        cw.done       = 1'b1;
      end
      MEMWRITE: begin
        cw.mem_req   = 1'b1;
        cw.mem_wait  = 1'b1;
        cw.adr_src   = 1'b1;
        cw.mem_write = 1'b1;
        cw.done      = 1'b1;
      end
      EXECR: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_RS2;
        cw.alu_op    = ALU_FUNCT;
      end
      EXECI: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_IMM;
        cw.alu_op    = ALU_FUNCT;
      end
      ALUWB: begin
        cw.reg_write = 1'b1;
        cw.done      = 1'b1;
      end
      BEQ: begin
        cw.alu_src_a = SRCA_RS1;
        cw.alu_src_b = SRCB_RS2;
        cw.alu_op    = ALU_SUB;
        cw.branch    = 1'b1;
        cw.done      = 1'b1;
      end
      JAL: begin
        cw.alu_src_a = SRCA_OLDPC;
        cw.alu_src_b = SRCB_FOUR;
        cw.pc_update = 1'b1;
      end
      TRAP: cw.illegal = 1'b1;
      default: cw = '0;
    endcase
  end
endmodule

// File: rtl/multicycle_main_controller.sv
// multicycle_main_controller: Moore FSM sequencing RV32I instructions over 3-5 cycles
module multicycle_main_controller
  import multicycle_main_controller_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter bit ILLEGAL_TRAP  = 1'b1,
  parameter int STATE_W       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUop,
  output logic [1:0] ImmSrc,
  output logic       illegal,
  output logic       instr_done
);
  logic [STATE_W-1:0] st;
  state_t cur, nxt;
  ctrl_t cw;
  logic rdy, gate, nop_done;
  assign cur = st > STATE_W'(TRAP) ? state_t'(4'hf) : state_t'(st[3:0]);
  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign gate = !cw.mem_wait || rdy;
  assign nop_done = cur == DECODE && !known_op(op) && !ILLEGAL_TRAP;
  multicycle_main_controller_state_out_decode u_decode (.s(cur), .cw(cw));
  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = rdy ? DECODE : FETCH;
      DECODE:   nxt = (op == OP_LW || op == OP_SW) ? MEMADR :
                      op == OP_R ? EXECR : op == OP_I ? EXECI :
                      op == OP_BEQ ? BEQ : op == OP_JAL ? JAL :
                      ILLEGAL_TRAP ? TRAP : FETCH;
      MEMADR:   nxt = op == OP_SW ? MEMWRITE : MEMREAD;
      MEMREAD:  nxt = rdy ? MEMWB : MEMREAD;
      MEMWRITE: nxt = rdy ? FETCH : MEMWRITE;
      EXECR, EXECI, JAL: nxt = ALUWB;
      TRAP:     nxt = TRAP;
      default:  nxt = FETCH;
    endcase
  end
  always_ff @(posedge clk) st <= rst ? STATE_W'(FETCH) : STATE_W'(nxt);
  assign mem_req    = cw.mem_req;
  assign AdrSrc     = cw.adr_src;
  assign ResultSrc  = cw.result_src;
  assign ALUSrcA    = cw.alu_src_a;
  assign ALUSrcB    = cw.alu_src_b;
  assign ALUop      = cw.alu_op;
  assign illegal    = cw.illegal;
  assign ImmSrc     = imm_src(op);
  assign PCWrite    = !rst && ((cw.branch && zero) || (cw.pc_update && gate));
  assign IRWrite    = !rst && cw.ir_write && gate;
  assign MemWrite   = !rst && cw.mem_write;
  assign RegWrite   = !rst && cw.reg_write;
  assign instr_done = !rst && ((cw.done && gate) || nop_done);
endmodule

// File: tb/tb_multicycle_main_controller.sv
// tb_multicycle_main_controller: directed cycle-by-cycle checks of the multicycle controller
module tb_multicycle_main_controller;
  logic clk = 1'b0, rst, zero, mem_ready;
  logic [6:0] op;
  logic mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, instr_done;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUop, ImmSrc;
  logic mem_req2, PCWrite2, AdrSrc2, MemWrite2, IRWrite2, RegWrite2, illegal2, instr_done2;
  logic [1:0] ResultSrc2, ALUSrcA2, ALUSrcB2, ALUop2, ImmSrc2;
  logic [15:0] cw;
  int passed = 0, total = 0;
  always #5 clk = ~clk;
  multicycle_main_controller dut (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUop(ALUop), .ImmSrc(ImmSrc), .illegal(illegal), .instr_done(instr_done)
  );
  multicycle_main_controller #(.ILLEGAL_TRAP(1'b0)) dut_nop (
    .clk(clk), .rst(rst), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req2), .PCWrite(PCWrite2), .AdrSrc(AdrSrc2), .MemWrite(MemWrite2),
    .IRWrite(IRWrite2), .RegWrite(RegWrite2), .ResultSrc(ResultSrc2), .ALUSrcA(ALUSrcA2),
    .ALUSrcB(ALUSrcB2), .ALUop(ALUop2), .ImmSrc(ImmSrc2), .illegal(illegal2), .instr_done(instr_done2)
  );
  assign cw = {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
               ResultSrc, ALUSrcA, ALUSrcB, ALUop, illegal, instr_done};
  localparam logic [15:0] FETCH_GO   = 16'b1_1_0_0_1_0_10_00_10_00_0_0;
  localparam logic [15:0] FETCH_HOLD = 16'b1_0_0_0_0_0_10_00_10_00_0_0;
  localparam logic [15:0] DECODE_W   = 16'b0_0_0_0_0_0_00_01_01_00_0_0;
  localparam logic [15:0] MEMADR_W   = 16'b0_0_0_0_0_0_00_10_01_00_0_0;
  localparam logic [15:0] MEMREAD_W  = 16'b1_0_1_0_0_0_00_00_00_00_0_0;
  localparam logic [15:0] MEMWB_W    = 16'b0_0_0_0_0_1_01_00_00_00_0_1;
  localparam logic [15:0] WR_DONE    = 16'b1_0_1_1_0_0_00_00_00_00_0_1;
  localparam logic [15:0] WR_WAIT    = 16'b1_0_1_1_0_0_00_00_00_00_0_0;
  localparam logic [15:0] WR_RST     = 16'b1_0_1_0_0_0_00_00_00_00_0_0;
  localparam logic [15:0] EXECR_W    = 16'b0_0_0_0_0_0_00_10_00_10_0_0;
  localparam logic [15:0] EXECI_W    = 16'b0_0_0_0_0_0_00_10_01_10_0_0;
  localparam logic [15:0] ALUWB_W    = 16'b0_0_0_0_0_1_00_00_00_00_0_1;
  localparam logic [15:0] BEQ_T      = 16'b0_1_0_0_0_0_00_10_00_01_0_1;
  localparam logic [15:0] BEQ_N      = 16'b0_0_0_0_0_0_00_10_00_01_0_1;
  localparam logic [15:0] JAL_W      = 16'b0_1_0_0_0_0_00_01_10_00_0_0;
  localparam logic [15:0] TRAP_W     = 16'b0_0_0_0_0_0_00_00_00_00_1_0;
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask
  task automatic step(input string tag, input logic [15:0] exp);
    #1;
    chk(tag, cw, exp);
    @(posedge clk);
    #1;
  endtask
  initial begin
    rst = 1'b1; zero = 1'b0; mem_ready = 1'b1; op = 7'b0000011;
    @(posedge clk);
    #1;
    step("rst_c0", FETCH_HOLD);
    step("rst_c1", FETCH_HOLD);
    rst = 1'b0;
    step("lw_fetch", FETCH_GO);
    chk("lw_imm", {14'b0, ImmSrc}, 16'd0);
    step("lw_decode", DECODE_W);
    step("lw_memadr", MEMADR_W);
    step("lw_memread", MEMREAD_W);
    step("lw_memwb", MEMWB_W);
    op = 7'b0100011; mem_ready = 1'b0;
    step("sw_fetch_stall", FETCH_HOLD);
    mem_ready = 1'b1;
    step("sw_fetch", FETCH_GO);
    chk("sw_imm", {14'b0, ImmSrc}, 16'd1);
    step("sw_decode", DECODE_W);
    step("sw_memadr", MEMADR_W);
    mem_ready = 1'b0;
    step("sw_wait0", WR_WAIT);
    step("sw_wait1", WR_WAIT);
    step("sw_wait2", WR_WAIT);
    mem_ready = 1'b1;
    step("sw_done", WR_DONE);
    op = 7'b0110011;
    step("r_fetch", FETCH_GO);
    step("r_decode", DECODE_W);
    step("r_exec", EXECR_W);
    step("r_wb", ALUWB_W);
    op = 7'b0010011;
    step("i_fetch", FETCH_GO);
    step("i_decode", DECODE_W);
    step("i_exec", EXECI_W);
    step("i_wb", ALUWB_W);
    op = 7'b1100011;
    step("beq1_fetch", FETCH_GO);
    chk("beq_imm", {14'b0, ImmSrc}, 16'd2);
    step("beq1_decode", DECODE_W);
    zero = 1'b1;
    step("beq1_taken", BEQ_T);
    zero = 1'b0;
    step("beq0_fetch", FETCH_GO);
    step("beq0_decode", DECODE_W);
    step("beq0_nottaken", BEQ_N);
    op = 7'b1101111;
    step("jal_fetch", FETCH_GO);
    chk("jal_imm", {14'b0, ImmSrc}, 16'd3);
    step("jal_decode", DECODE_W);
    step("jal_exec", JAL_W);
    step("jal_wb", ALUWB_W);
    op = 7'b1111111;
    step("ill_fetch", FETCH_GO);
    chk("nop_decode_done", {15'b0, instr_done2}, 16'd1);
    chk("trap_decode_nodone", {15'b0, instr_done}, 16'd0);
    step("ill_decode", DECODE_W);
    chk("nop_back_fetch", {15'b0, IRWrite2}, 16'd1);
    step("trap_c3", TRAP_W);
    step("trap_c4", TRAP_W);
    step("trap_c5", TRAP_W);
    rst = 1'b1;
    step("trap_rst", TRAP_W);
    rst = 1'b0; op = 7'b0100011;
    step("trap_cleared", FETCH_GO);
    step("swr_decode", DECODE_W);
    step("swr_memadr", MEMADR_W);
    mem_ready = 1'b0;
    step("swr_wait", WR_WAIT);
    rst = 1'b1;
    step("swr_rst", WR_RST);
    rst = 1'b0; mem_ready = 1'b1;
    step("swr_fetch", FETCH_GO);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
